// File: rtl/pio_poll_pkg.sv
// Shared definitions for the Avalon PIO poll master: FSM encoding,
// default Avalon widths and the counter-width helper.
package pio_poll_pkg;

   // Poll FSM encoding, kept as plain 2-bit constants for legacy tools
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_LAT  = 2'd2;
   localparam logic [1:0] ST_EVAL = 2'd3;

   // Default Avalon-MM widths for a standard PIO data register
   localparam int DEFAULT_DATA_W = 32;
   localparam int DEFAULT_ADDR_W = 2;

   // Bits needed to count 0..value-1, never less than one
   function automatic int clog2(input int value);
      int result;
      int remaining;
      result    = 0;
      remaining = value - 1;
      while (remaining > 0) begin
         result++;
         remaining = remaining >> 1;
      end
      return (result < 1) ? 1 : result;
   endfunction

endpackage

// File: rtl/poll_tick_gen.sv
// Period counter that emits a one-cycle tick every PERIOD cycles while
// enabled and sits at zero while disabled.
module poll_tick_gen
   import pio_poll_pkg::*;
#(
   parameter int PERIOD = 50000
)(
   input  logic i_clk,
   input  logic i_reset_n,
   input  logic i_enable,
   output logic o_tick
);

   localparam int               CNT_W = clog2(PERIOD);
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(PERIOD - 1);

   logic [CNT_W-1:0] r_count;

   // Free-running 0..PERIOD-1 count, parked at zero when polling is off
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_count <= '0;
      end else if (!i_enable) begin
         r_count <= '0;
      end else if (r_count == LAST) begin
         r_count <= '0;
      end else begin
         r_count <= r_count + CNT_W'(1);
      end
   end

   assign o_tick = i_enable && (r_count == LAST);

endmodule

// File: rtl/avalon_pio_poll_master.sv
// Avalon-MM read master that periodically polls a PIO data register,
// debounces the returned word and publishes it with a change pulse.
module avalon_pio_poll_master
   import pio_poll_pkg::*;
#(
   parameter int DATA_W       = DEFAULT_DATA_W,
   parameter int ADDR_W       = DEFAULT_ADDR_W,
   parameter int POLL_ADDR    = 0,
   parameter int POLL_PERIOD  = 50000,
   parameter int READ_LATENCY = 1,
   parameter int DEBOUNCE_CNT = 4
)(
   input  logic              clk,
   input  logic              reset_n,
   input  logic              enable,
   output logic [ADDR_W-1:0] avm_address,
   output logic              avm_read,
   input  logic              avm_waitrequest,
   input  logic [DATA_W-1:0] avm_readdata,
   output logic [DATA_W-1:0] sample,
   output logic [DATA_W-1:0] stable,
   output logic              changed,
   output logic              busy
);

   localparam logic [2:0] LAT_LAST = 3'(READ_LATENCY);
   localparam logic [3:0] DEB_MAX  = 4'(DEBOUNCE_CNT);

   logic              w_tick;
   logic [1:0]        r_state;
   logic [2:0]        r_latCnt;
   logic [DATA_W-1:0] r_sample;
   logic [DATA_W-1:0] r_candidate;
   logic [3:0]        r_count;
   logic [DATA_W-1:0] r_stable;
   logic              r_changed;

   logic              w_match;
   logic [3:0]        w_nextCount;
   logic [DATA_W-1:0] w_nextCandidate;
   logic              w_update;

   poll_tick_gen #(
      .PERIOD (POLL_PERIOD)
   ) u_tick (
      .i_clk     (clk),
      .i_reset_n (reset_n),
      .i_enable  (enable),
      .o_tick    (w_tick)
   );

   // Poll sequencing; ticks outside IDLE are simply ignored so reads never queue
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state  <= ST_IDLE;
         r_latCnt <= 3'd0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_tick) begin
                  r_state <= ST_REQ;
               end
            end
            ST_REQ: begin
               if (!avm_waitrequest) begin
                  r_state  <= ST_LAT;
                  r_latCnt <= 3'd1;
               end
            end
            ST_LAT: begin
               if (r_latCnt == LAT_LAST) begin
                  r_state <= ST_EVAL;
               end else begin
                  r_latCnt <= r_latCnt + 3'd1;
               end
            end
            ST_EVAL: begin
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   // Capture the slave word on the edge closing the last latency cycle
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sample <= '0;
      end else if ((r_state == ST_LAT) && (r_latCnt == LAT_LAST)) begin
         r_sample <= avm_readdata;
      end
   end

   // Next debounce candidate/count, and whether this EVAL promotes the candidate
   always_comb begin
      w_match         = (r_sample == r_candidate);
      w_nextCandidate = r_candidate;
      w_nextCount     = r_count;
      w_update        = 1'b0;
      if (w_match) begin
         w_nextCount = (r_count >= DEB_MAX) ? DEB_MAX : (r_count + 4'd1);
      end else begin
         w_nextCandidate = r_sample;
         w_nextCount     = 4'd1;
      end
      w_update = (w_nextCount == DEB_MAX) && (w_nextCandidate != r_stable);
   end

   // Debounce state update once per poll, with a single-cycle change pulse
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_candidate <= '0;
         r_count     <= 4'd0;
         r_stable    <= '0;
         r_changed   <= 1'b0;
      end else begin
         r_changed <= 1'b0;
         if (r_state == ST_EVAL) begin
            r_candidate <= w_nextCandidate;
            r_count     <= w_nextCount;
            if (w_update) begin
               r_stable  <= w_nextCandidate;
               r_changed <= 1'b1;
            end
         end
      end
   end

   assign avm_address = ADDR_W'(POLL_ADDR);
   assign avm_read    = (r_state == ST_REQ);
   assign busy        = (r_state == ST_REQ) || (r_state == ST_LAT);
   assign sample      = r_sample;
   assign stable      = r_stable;
   assign changed     = r_changed;

endmodule
